alu_seq_unit: RTL and testbench
===============================

// Module: alu_seq_unit
// PURPOSE
//  Arithmetic/logic unit that consumes the system controller's ALU_EN/ALU_FUN command and returns a 16-bit result with a one-cycle ALU_OUT_VLD pulse.
//  Operands A/B come from register-file entries REG0/REG1. The block runs on the CLKG_EN-gated clock.
//  Single-cycle logic/add/sub ops; MUL and DIV are iterative (shift-add / restoring divide) to save area.
// PARAMETERS
//  OPER_WIDTH  8   operand width (A, B)
//  OUT_WIDTH   16  result width; fixed at 2*OPER_WIDTH
//  FUN_WIDTH   4   ALU_FUN width
// PORTS
//  CLK          in   1           gated ALU clock; single clock domain
//  RST          in   1           asynchronous, active-low reset
//  A            in   OPER_WIDTH  operand A (REG0)
//  B            in   OPER_WIDTH  operand B (REG1)
//  ALU_FUN      in   FUN_WIDTH   function code, sampled with ALU_EN
//  ALU_EN       in   1           operation request, level; controller holds it high until ALU_OUT_VLD
//  ALU_OUT      out  OUT_WIDTH   result, registered; holds last result between ops
//  ALU_OUT_VLD  out  1           one-cycle pulse: ALU_OUT valid in the same cycle
//  ALU_ERR      out  1           only with ALU_ERR_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset: ALU_OUT=0, ALU_OUT_VLD=0, ALU_ERR=0, state=IDLE, iteration count=0.
//  FSM: IDLE -> BUSY -> HOLD -> IDLE.
//   IDLE: ALU_EN=1 at an edge latches A, B, ALU_FUN. Simple op -> HOLD; MUL/DIV -> BUSY.
//   BUSY: one iteration per cycle, 8 iterations (OPER_WIDTH); after the last iteration -> HOLD.
//   HOLD: ALU_OUT_VLD=1 only in the first HOLD cycle. Stay in HOLD while ALU_EN=1; ALU_EN=0 -> IDLE.
//   ALU_EN held high after a result never retriggers an op.
//  Latency, from the edge that samples ALU_EN: simple ops = 1 cycle; MUL/DIV = 1+OPER_WIDTH = 9 cycles.
//  ALU_EN=0 during BUSY: abort to IDLE. No ALU_OUT_VLD. ALU_OUT keeps its previous value.
//  ALU_OUT and ALU_OUT_VLD update on the same edge (registered together).
//  Function codes (zero-extended to 16 bits unless stated):
//   0 ADD   A+B, carry in bit 8
//   1 SUB   A-B, wraps mod 2^16 (3-5 = 16'hFFFE)
//   2 MUL   A*B, full 16 bits
//   3 DIV   quotient in [7:0], remainder in [15:8]
//   4 AND   5 OR   6 NAND   7 NOR   8 XOR   9 XNOR (bitwise, upper byte 0)
//   A EQ    1 if A==B, else 0
//   B GT    2 if A>B, else 0
//   C LT    3 if A<B, else 0
//   D SHR   A>>1
//   E SHL   A<<1 (bit 8 kept)
//   F NOP   result 0, still pulses ALU_OUT_VLD
//  Divide by zero: quotient=8'hFF, remainder=A, latency unchanged (9 cycles).
//  Operands change during BUSY: ignored; the latched copies are used.
//  Reset mid-operation: immediate return to reset values; no pulse after reset release until a new ALU_EN.
// CONFIGURATION
//  Macro ALU_ERR_EN:
//   defined  -> ALU_ERR port present. Set with the ALU_OUT_VLD pulse when DIV has B==0; cleared on the next accepted op.
//   undefined -> no ALU_ERR port; divide-by-zero gives only the fixed result above.
// STRUCTURE
//  Shared package sys_ctrl_pkg: ALU function-code constants (ALU_ADD..ALU_NOP), ALU FSM state encoding, OPER_WIDTH default.
//  Sub-module alu_muldiv_iter: shift-add multiplier plus restoring divider sharing a 16-bit accumulator and a 3-bit counter.
//   Interface: start/op/a/b in, done/result out. Top keeps the FSM, single-cycle datapath and output registers.
// TESTING
//  1. ADD A=8'hFF B=8'h01, EN high -> next cycle ALU_OUT=16'h0100, VLD pulses once, no second pulse while EN held.
//  2. SUB A=3 B=5 -> 16'hFFFE after 1 cycle; GT A=9 B=4 -> 16'h0002; LT A=4 B=9 -> 16'h0003.
//  3. MUL A=8'hFF B=8'hFF -> ALU_OUT=16'hFE01, VLD exactly 9 cycles after the EN-sampling edge.
//  4. DIV A=200 B=7 -> 16'h041C (rem 4, quo 28). DIV A=5 B=0 -> 16'h05FF; ALU_ERR=1 when ALU_ERR_EN defined.
//  5. MUL started, EN dropped in cycle 4 -> no VLD, ALU_OUT unchanged; a fresh ADD then completes normally.
//  6. RST asserted mid-DIV -> ALU_OUT=0, VLD=0 immediately; after release with EN=0, VLD stays 0.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// Shared system-controller definitions: ALU function codes,
// ALU FSM state encoding, operand widths and the single-cycle op function.
package sys_ctrl_pkg;

    localparam int OPER_WIDTH = 8;
    localparam int OUT_WIDTH  = 2 * OPER_WIDTH;
    localparam int FUN_WIDTH  = 4;
    localparam int CNT_WIDTH  = $clog2(OPER_WIDTH);

    localparam logic [FUN_WIDTH-1:0] ALU_ADD  = 4'h0;
    localparam logic [FUN_WIDTH-1:0] ALU_SUB  = 4'h1;
    localparam logic [FUN_WIDTH-1:0] ALU_MUL  = 4'h2;
    localparam logic [FUN_WIDTH-1:0] ALU_DIV  = 4'h3;
    localparam logic [FUN_WIDTH-1:0] ALU_AND  = 4'h4;
    localparam logic [FUN_WIDTH-1:0] ALU_OR   = 4'h5;
    localparam logic [FUN_WIDTH-1:0] ALU_NAND = 4'h6;
    localparam logic [FUN_WIDTH-1:0] ALU_NOR  = 4'h7;
    localparam logic [FUN_WIDTH-1:0] ALU_XOR  = 4'h8;
    localparam logic [FUN_WIDTH-1:0] ALU_XNOR = 4'h9;
    localparam logic [FUN_WIDTH-1:0] ALU_EQ   = 4'hA;
    localparam logic [FUN_WIDTH-1:0] ALU_GT   = 4'hB;
    localparam logic [FUN_WIDTH-1:0] ALU_LT   = 4'hC;
    localparam logic [FUN_WIDTH-1:0] ALU_SHR  = 4'hD;
    localparam logic [FUN_WIDTH-1:0] ALU_SHL  = 4'hE;
    localparam logic [FUN_WIDTH-1:0] ALU_NOP  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_HOLD
    } alu_state_t;

    function automatic logic [OUT_WIDTH-1:0] alu_simple(
        input logic [FUN_WIDTH-1:0]  fun,
        input logic [OPER_WIDTH-1:0] a,
        input logic [OPER_WIDTH-1:0] b
    );
        logic [OUT_WIDTH-1:0] za;
        logic [OUT_WIDTH-1:0] zb;
        za = {{OPER_WIDTH{1'b0}}, a};
        zb = {{OPER_WIDTH{1'b0}}, b};
        case (fun)
            ALU_ADD:  return za + zb;
            ALU_SUB:  return za - zb;
            ALU_AND:  return za & zb;
            ALU_OR:   return za | zb;
            ALU_NAND: return {{OPER_WIDTH{1'b0}}, ~(a & b)};
            ALU_NOR:  return {{OPER_WIDTH{1'b0}}, ~(a | b)};
            ALU_XOR:  return za ^ zb;
            ALU_XNOR: return {{OPER_WIDTH{1'b0}}, ~(a ^ b)};
            ALU_EQ:   return (a == b) ? 16'd1 : 16'd0;
            ALU_GT:   return (a > b) ? 16'd2 : 16'd0;
            ALU_LT:   return (a < b) ? 16'd3 : 16'd0;
            ALU_SHR:  return za >> 1;
            ALU_SHL:  return za << 1;
            default:  return '0;
        endcase
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider sharing one
// accumulator; done/result are combinational on the final iteration.
module alu_muldiv_iter
    import sys_ctrl_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  op,
    input  logic [OPER_WIDTH-1:0] a,
    input  logic [OPER_WIDTH-1:0] b,
    output logic                  done,
    output logic [OUT_WIDTH-1:0]  result
);

    logic [OUT_WIDTH-1:0]  acc;
    logic [OPER_WIDTH-1:0] a_r;
    logic [OPER_WIDTH-1:0] b_r;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  busy;
    logic                  op_r;

    logic [OPER_WIDTH:0]   trial;
    logic [OPER_WIDTH:0]   diff;
    logic [OUT_WIDTH-1:0]  mul_nxt;
    logic [OUT_WIDTH-1:0]  div_nxt;

    // Divide keeps {remainder, quotient} in acc and shifts the dividend
    // out of the low byte one bit per step.
    always_comb begin
        trial   = {acc[OUT_WIDTH-1:OPER_WIDTH], acc[OPER_WIDTH-1]};
        diff    = trial - {1'b0, b_r};
        div_nxt = {trial[OPER_WIDTH-1:0], acc[OPER_WIDTH-2:0], 1'b0};
        if (trial >= {1'b0, b_r}) begin
            div_nxt[OUT_WIDTH-1:OPER_WIDTH] = diff[OPER_WIDTH-1:0];
            div_nxt[0] = 1'b1;
        end
        mul_nxt = acc;
        if (b_r[cnt])
            mul_nxt = acc + ({{OPER_WIDTH{1'b0}}, a_r} << cnt);
    end

    assign result = op_r ? div_nxt : mul_nxt;
    assign done   = busy && (cnt == CNT_WIDTH'(OPER_WIDTH - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc  <= '0;
            a_r  <= '0;
            b_r  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            op_r <= 1'b0;
        end else if (start) begin
            acc  <= op ? {{OPER_WIDTH{1'b0}}, a} : '0;
            a_r  <= a;
            b_r  <= b;
            cnt  <= '0;
            busy <= 1'b1;
            op_r <= op;
        end else if (busy) begin
            acc <= result;
            cnt <= cnt + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// ALU with single-cycle logic/arith ops and iterative MUL/DIV.
// Define ALU_ERR_EN to add the ALU_ERR divide-by-zero flag.
module alu_seq_unit
    import sys_ctrl_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [OPER_WIDTH-1:0] A,
    input  logic [OPER_WIDTH-1:0] B,
    input  logic [FUN_WIDTH-1:0]  ALU_FUN,
    input  logic                  ALU_EN,
    output logic [OUT_WIDTH-1:0]  ALU_OUT,
    output logic                  ALU_OUT_VLD
`ifdef ALU_ERR_EN
    ,
    output logic                  ALU_ERR
`endif
);

    alu_state_t           state;
    logic                 is_iter;
    logic                 start;
    logic                 done;
    logic [OUT_WIDTH-1:0] iter_res;

    assign is_iter = (ALU_FUN == ALU_MUL) || (ALU_FUN == ALU_DIV);
    assign start   = (state == ST_IDLE) && ALU_EN && is_iter;

    alu_muldiv_iter u_iter (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .op     (ALU_FUN == ALU_DIV),
        .a      (A),
        .b      (B),
        .done   (done),
        .result (iter_res)
    );

`ifdef ALU_ERR_EN
    logic dz_r;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            dz_r    <= 1'b0;
            ALU_ERR <= 1'b0;
        end else if (state == ST_IDLE && ALU_EN) begin
            dz_r    <= (ALU_FUN == ALU_DIV) && (B == '0);
            ALU_ERR <= 1'b0;
        end else if (state == ST_BUSY && ALU_EN && done) begin
            ALU_ERR <= dz_r;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= ST_IDLE;
            ALU_OUT     <= '0;
            ALU_OUT_VLD <= 1'b0;
        end else begin
            ALU_OUT_VLD <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ALU_EN && is_iter) begin
                        state <= ST_BUSY;
                    end else if (ALU_EN) begin
                        ALU_OUT     <= alu_simple(ALU_FUN, A, B);
                        ALU_OUT_VLD <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
                // Dropping ALU_EN mid-iteration abandons the op silently.
                ST_BUSY: begin
                    if (!ALU_EN) begin
                        state <= ST_IDLE;
                    end else if (done) begin
                        ALU_OUT     <= iter_res;
                        ALU_OUT_VLD <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!ALU_EN)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed self-checking bench for alu_seq_unit.
// Build with +define+ALU_ERR_EN to also check the error flag.
module tb_alu_seq_unit;
    import sys_ctrl_pkg::*;

    logic        CLK;
    logic        RST;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
`ifdef ALU_ERR_EN
    logic        ALU_ERR;
`endif

    int total = 0;
    int bad   = 0;

    alu_seq_unit dut (
        .CLK         (CLK),
        .RST         (RST),
        .A           (A),
        .B           (B),
        .ALU_FUN     (ALU_FUN),
        .ALU_EN      (ALU_EN),
        .ALU_OUT     (ALU_OUT),
        .ALU_OUT_VLD (ALU_OUT_VLD)
`ifdef ALU_ERR_EN
        ,
        .ALU_ERR     (ALU_ERR)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag,
                          input logic [3:0] fun,
                          input logic [7:0] a,
                          input logic [7:0] b,
                          input logic [15:0] exp,
                          input int lat,
                          input bit scramble);
        int n;
        int extra;
        @(negedge CLK);
        A = a;
        B = b;
        ALU_FUN = fun;
        ALU_EN = 1'b1;
        @(posedge CLK);
        #1;
        n = 1;
        if (scramble) begin
            A = ~a;
            B = 8'h00;
        end
        while (ALU_OUT_VLD !== 1'b1 && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 16'(n), 16'(lat));
        chk(tag, ALU_OUT, exp);
        extra = 0;
        repeat (3) begin
            @(posedge CLK);
            #1;
            if (ALU_OUT_VLD !== 1'b0) extra++;
        end
        chk({tag, "_repulse"}, 16'(extra), 16'd0);
        chk({tag, "_hold"}, ALU_OUT, exp);
        @(negedge CLK);
        ALU_EN = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int pulses;
        RST = 1'b0;
        A = 8'h00;
        B = 8'h00;
        ALU_FUN = ALU_NOP;
        ALU_EN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out", ALU_OUT, 16'h0000);
        chk("rst_vld", {15'd0, ALU_OUT_VLD}, 16'd0);
`ifdef ALU_ERR_EN
        chk("rst_err", {15'd0, ALU_ERR}, 16'd0);
`endif
        @(negedge CLK);
        RST = 1'b1;

        run_op("add_ff_01", ALU_ADD, 8'hFF, 8'h01, 16'h0100, 1, 1'b0);
        run_op("sub_3_5",   ALU_SUB, 8'd3,  8'd5,  16'hFFFE, 1, 1'b0);
        run_op("gt_9_4",    ALU_GT,  8'd9,  8'd4,  16'h0002, 1, 1'b0);
        run_op("gt_4_9",    ALU_GT,  8'd4,  8'd9,  16'h0000, 1, 1'b0);
        run_op("lt_4_9",    ALU_LT,  8'd4,  8'd9,  16'h0003, 1, 1'b0);
        run_op("eq_7_7",    ALU_EQ,  8'd7,  8'd7,  16'h0001, 1, 1'b0);
        run_op("xor",       ALU_XOR, 8'hA5, 8'h0F, 16'h00AA, 1, 1'b0);
        run_op("nand",      ALU_NAND, 8'hF0, 8'hCC, 16'h003F, 1, 1'b0);
        run_op("xnor",      ALU_XNOR, 8'hF0, 8'hCC, 16'h00C3, 1, 1'b0);
        run_op("shl_81",    ALU_SHL, 8'h81, 8'h00, 16'h0102, 1, 1'b0);
        run_op("shr_81",    ALU_SHR, 8'h81, 8'h00, 16'h0040, 1, 1'b0);
        run_op("nop",       ALU_NOP, 8'h12, 8'h34, 16'h0000, 1, 1'b0);

        run_op("mul_ff_ff", ALU_MUL, 8'hFF, 8'hFF, 16'hFE01, 9, 1'b0);
        run_op("mul_0d_0b", ALU_MUL, 8'h0D, 8'h0B, 16'h008F, 9, 1'b0);
        run_op("div_200_7", ALU_DIV, 8'd200, 8'd7, 16'h041C, 9, 1'b0);
`ifdef ALU_ERR_EN
        chk("div_ok_err", {15'd0, ALU_ERR}, 16'd0);
`endif
        run_op("div_5_0",   ALU_DIV, 8'd5,  8'd0,  16'h05FF, 9, 1'b0);
`ifdef ALU_ERR_EN
        chk("div0_err", {15'd0, ALU_ERR}, 16'd1);
`endif
        run_op("add_7f_01", ALU_ADD, 8'h7F, 8'h01, 16'h0080, 1, 1'b0);
`ifdef ALU_ERR_EN
        chk("err_clear", {15'd0, ALU_ERR}, 16'd0);
`endif
        run_op("mul_scram", ALU_MUL, 8'h12, 8'h34, 16'h03A8, 9, 1'b1);

        // Abort: drop EN while the multiply is still iterating.
        @(negedge CLK);
        A = 8'h0F;
        B = 8'h0F;
        ALU_FUN = ALU_MUL;
        ALU_EN = 1'b1;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        ALU_EN = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge CLK);
            #1;
            if (ALU_OUT_VLD !== 1'b0) pulses++;
        end
        chk("abort_vld", 16'(pulses), 16'd0);
        chk("abort_out", ALU_OUT, 16'h03A8);
        run_op("add_after", ALU_ADD, 8'h10, 8'h20, 16'h0030, 1, 1'b0);
        run_op("mul_after", ALU_MUL, 8'h03, 8'h05, 16'h000F, 9, 1'b0);

        // Reset in the middle of a divide.
        @(negedge CLK);
        A = 8'd200;
        B = 8'd7;
        ALU_FUN = ALU_DIV;
        ALU_EN = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        ALU_EN = 1'b0;
        #1;
        chk("rstmid_out", ALU_OUT, 16'h0000);
        chk("rstmid_vld", {15'd0, ALU_OUT_VLD}, 16'd0);
        @(negedge CLK);
        RST = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(posedge CLK);
            #1;
            if (ALU_OUT_VLD !== 1'b0) pulses++;
        end
        chk("rstrel_vld", 16'(pulses), 16'd0);
        chk("rstrel_out", ALU_OUT, 16'h0000);
        run_op("add_1_2", ALU_ADD, 8'd1, 8'd2, 16'h0003, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
